// File: rtl/aes_pkg.sv
// Shared AES constants: key-size encoding, field polynomial, Rcon counts and
// the final forward Rcon byte per key size (the starting point of a reverse walk).
package aes_pkg;

   localparam logic [1:0] AES128 = 2'd0;
   localparam logic [1:0] AES192 = 2'd1;
   localparam logic [1:0] AES256 = 2'd2;

   localparam logic [7:0] AES_POLY = 8'h1b;

   localparam int RCON_CNT_128 = 10;
   localparam int RCON_CNT_192 = 8;
   localparam int RCON_CNT_256 = 7;

   localparam logic [7:0] RCON_LAST_128 = 8'h36;
   localparam logic [7:0] RCON_LAST_192 = 8'h80;
   localparam logic [7:0] RCON_LAST_256 = 8'h40;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // Encoding 3 is not a real key size and falls back to AES-128.
   function automatic int rcon_count(input logic [1:0] ks);
      case (ks)
         AES192:  return RCON_CNT_192;
         AES256:  return RCON_CNT_256;
         default: return RCON_CNT_128;
      endcase
   endfunction

   function automatic logic [7:0] rcon_last(input logic [1:0] ks);
      case (ks)
         AES192:  return RCON_LAST_192;
         AES256:  return RCON_LAST_256;
         default: return RCON_LAST_128;
      endcase
   endfunction

endpackage

// File: rtl/rcon_sequencer_if.sv
// Handshake bundle between the key-expansion controller (master) and the
// Rcon sequencer (slave).
interface rcon_sequencer_if #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 4
);

   logic              start;
   logic [1:0]        key_size;
   logic              reverse;
   logic              out_ready;
   logic              out_valid;
   logic [WORD_W-1:0] rcon_word;
   logic [IDX_W-1:0]  rcon_idx;
   logic              last;
   logic              busy;
   logic              done;

   modport master (
      output start, key_size, reverse, out_ready,
      input  out_valid, rcon_word, rcon_idx, last, busy, done
   );

   modport slave (
      input  start, key_size, reverse, out_ready,
      output out_valid, rcon_word, rcon_idx, last, busy, done
   );

endinterface

// File: rtl/gf_xtime.sv
// Single GF(2^8) step: multiply by x (xtime) or divide by x (inv_xtime),
// selected by i_inv. Purely combinational; also shared with MixColumns.
module gf_xtime
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   input  logic       i_inv,
   output logic [7:0] o_byte
);

   logic [7:0] w_fwd;
   logic [7:0] w_xor;
   logic [7:0] w_inv;

   assign w_fwd = {i_byte[6:0], 1'b0} ^ (i_byte[7] ? AES_POLY : 8'h00);

   // An odd byte had the polynomial folded in on the forward step, so undo it first.
   assign w_xor = i_byte ^ AES_POLY;
   assign w_inv = i_byte[0] ? {1'b1, w_xor[7:1]} : {1'b0, i_byte[7:1]};

   assign o_byte = i_inv ? w_inv : w_fwd;

endmodule

// File: rtl/rcon_sequencer.sv
// Streams the AES Rcon sequence for a 128/192/256-bit key over valid/ready.
// Optional macro RCON_REVERSE_EN enables descending (inverse key schedule) order.
module rcon_sequencer
   import aes_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 4
) (
   input logic              clk,
   input logic              rst_n,
   rcon_sequencer_if.slave  bus
);

   seq_state_t        r_state;
   logic [7:0]        r_byte;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_n;
   logic              r_rev;
   logic              r_valid;
   logic              r_last;
   logic              r_busy;
   logic              r_done;

   logic [7:0]        w_nextByte;
   logic [IDX_W-1:0]  w_nextIdx;
   logic              w_nextLast;
   logic [IDX_W-1:0]  w_startN;
   logic              w_startRev;
   logic [7:0]        w_startByte;
   logic [IDX_W-1:0]  w_startIdx;
   logic              w_startLast;
   logic [WORD_W-1:0] w_word;

`ifdef RCON_REVERSE_EN
   assign w_startRev = bus.reverse;
`else
   // Forward-only build: r_rev stays 0, so the inverse path folds away.
   logic w_unused;
   assign w_unused   = bus.reverse;
   assign w_startRev = 1'b0;
`endif

   gf_xtime u_xtime (
      .i_byte (r_byte),
      .i_inv  (r_rev),
      .o_byte (w_nextByte)
   );

   assign w_nextIdx   = r_rev ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
   assign w_nextLast  = r_rev ? (w_nextIdx == IDX_W'(1)) : (w_nextIdx == r_n);

   assign w_startN    = IDX_W'(rcon_count(bus.key_size));
   assign w_startByte = w_startRev ? rcon_last(bus.key_size) : 8'h01;
   assign w_startIdx  = w_startRev ? w_startN : IDX_W'(1);
   assign w_startLast = (w_startN == IDX_W'(1));

   always_comb begin
      w_word = '0;
      w_word[WORD_W-1 -: 8] = r_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_byte  <= '0;
         r_idx   <= '0;
         r_n     <= '0;
         r_rev   <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_n     <= w_startN;
                  r_rev   <= w_startRev;
                  r_byte  <= w_startByte;
                  r_idx   <= w_startIdx;
                  r_last  <= w_startLast;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_valid && bus.out_ready) begin
                  if (r_last) begin
                     r_byte  <= '0;
                     r_idx   <= '0;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_byte  <= w_nextByte;
                     r_idx   <= w_nextIdx;
                     r_last  <= w_nextLast;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.rcon_word = w_word;
   assign bus.rcon_idx  = r_idx;
   assign bus.last      = r_last;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_rcon_sequencer.sv
// Scoreboard bench for rcon_sequencer: expected words are queued at start and
// popped on every accepted transfer.
module tb_rcon_sequencer;
   import aes_pkg::*;

   localparam int WORD_W = 32;
   localparam int IDX_W  = 4;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   exp_t sb[$];
   logic [7:0] fwdTable [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   rcon_sequencer_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) bus ();

   rcon_sequencer #(.WORD_W(WORD_W), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "Word"},  32'(bus.rcon_word), 32'd0);
      checkOutput({tag, "Idx"},   32'(bus.rcon_idx),  32'd0);
      checkOutput({tag, "Last"},  32'(bus.last),      32'd0);
      checkOutput({tag, "Busy"},  32'(bus.busy),      32'd0);
      checkOutput({tag, "Done"},  32'(bus.done),      32'd0);
   endtask

   // Queue the expected sequence, then pulse start for one cycle while idle.
   task automatic applyStimulus(input logic [1:0] ks, input logic rev, output int n);
      bit   effRev;
      int   k;
      exp_t e;
      n = (ks == AES192) ? 8 : (ks == AES256) ? 7 : 10;
`ifdef RCON_REVERSE_EN
      effRev = rev;
`else
      effRev = 1'b0;
`endif
      for (int i = 0; i < n; i++) begin
         k = effRev ? (n - 1 - i) : i;
         e.word = {fwdTable[k], 24'h000000};
         e.idx  = IDX_W'(k + 1);
         e.last = (i == n - 1);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_size = ks;
      bus.reverse  = rev;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
   task automatic runSequence(input int n, input int mode, input bit poke, input int abortAfter);
      int                c = 0;
      int                xfers = 0;
      bit                fin = 1'b0;
      bit                stalled = 1'b0;
      logic [WORD_W-1:0] hw = '0;
      logic [IDX_W-1:0]  hi = '0;
      logic              hl = 1'b0;
      exp_t              e;
      @(negedge clk);
      checkOutput("firstValid", 32'(bus.out_valid), 32'd1);
      while (!fin && c < 200) begin
         if (c > 0) @(negedge clk);
         checkOutput("busyRun", 32'(bus.busy), 32'd1);
         if (stalled) begin
            checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
            checkOutput("holdWord",  32'(bus.rcon_word), 32'(hw));
            checkOutput("holdIdx",   32'(bus.rcon_idx),  32'(hi));
            checkOutput("holdLast",  32'(bus.last),      32'(hl));
         end
         hw = bus.rcon_word;
         hi = bus.rcon_idx;
         hl = bus.last;
         if (poke) begin
            bus.start = (c == 2);
            if (c == 2) begin
               bus.key_size = AES256;
               bus.reverse  = 1'b1;
            end
         end
         bus.out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
         if (bus.out_valid && bus.out_ready) begin
            stalled = 1'b0;
            if (sb.size() == 0) begin
               checkOutput("extraWord", 32'(xfers + 1), 32'(n));
               fin = 1'b1;
            end else begin
               e = sb.pop_front();
               checkOutput("word", 32'(bus.rcon_word), 32'(e.word));
               checkOutput("idx",  32'(bus.rcon_idx),  32'(e.idx));
               checkOutput("last", 32'(bus.last),      32'(e.last));
               xfers++;
               if (e.last) fin = 1'b1;
            end
            if (abortAfter != 0 && xfers == abortAfter) return;
         end else begin
            stalled = bus.out_valid;
         end
         c++;
      end
      if (!fin) checkOutput("timeout", 32'(c), 32'd200 - 32'd1);
      checkOutput("xferCount", 32'(xfers), 32'(n));
      if (mode == 0) checkOutput("fullRateCycles", 32'(c), 32'(n));
      @(negedge clk);
      checkOutput("doneHigh",  32'(bus.done),      32'd1);
      checkOutput("validLow",  32'(bus.out_valid), 32'd0);
      checkOutput("busyLow",   32'(bus.busy),      32'd0);
      @(negedge clk);
      checkOutput("donePulse", 32'(bus.done),      32'd0);
   endtask

   initial begin
      int n;
      bus.start     = 1'b0;
      bus.key_size  = 2'd0;
      bus.reverse   = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] AES-128 forward, full rate");
      applyStimulus(AES128, 1'b0, n);
      runSequence(n, 0, 1'b0, 0);

      $display("[TB] AES-192 reverse request");
      applyStimulus(AES192, 1'b1, n);
      runSequence(n, 0, 1'b0, 0);

      $display("[TB] AES-256 forward, ready 1,0,0");
      applyStimulus(AES256, 1'b0, n);
      runSequence(n, 1, 1'b0, 0);

      $display("[TB] AES-128 with start and key_size poked mid-run");
      applyStimulus(AES128, 1'b0, n);
      runSequence(n, 0, 1'b1, 0);

      $display("[TB] AES-128 reset after 4th word");
      applyStimulus(AES128, 1'b0, n);
      runSequence(n, 0, 1'b0, 4);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("midReset");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(AES128, 1'b0, n);
      runSequence(n, 0, 1'b0, 0);

      $display("[TB] key_size 3 behaves as AES-128");
      applyStimulus(2'd3, 1'b0, n);
      runSequence(10, 0, 1'b0, 0);

      checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
